fibonacci_seq_gen: RTL and testbench
====================================

// Module: fibonacci_seq_gen
//
// PURPOSE
//   Parametrised successor of the free-running Fibonacci generator. Each job is
//   accepted over a valid/ready start interface and carries programmable seeds
//   (x0, x1), a term count N and an overflow mode. The block then streams N
//   terms, x0, x1, x0+x1, ..., over a valid/ready output at up to one term per
//   cycle. Each term carries its index, a last flag and an overflow flag.
//   Serves as a sequence/stimulus source for downstream datapath blocks.
//
// PARAMETERS
//   W      32  term datapath width; all sums are modulo 2^W
//   CNT_W  16  width of term count N and of term index
//
// PORTS
//   clk         in   1      clock; all logic on posedge
//   rst_n       in   1      synchronous reset, active-low
//   start_vld   in   1      job request valid
//   start_rdy   out  1      job request ready; 1 only in IDLE
//   start_x0    in   W      seed term 0
//   start_x1    in   W      seed term 1
//   start_n     in   CNT_W  number of terms to emit; 0 means accept and emit nothing
//   start_mode  in   1      0 = WRAP (emit wrapped terms, flag ovf); 1 = STOP (end before first wrapped term)
//   abort       in   1      cancel the current job; honoured in RUN only
//   out_vld     out  1      term valid
//   out_rdy     in   1      term ready (downstream)
//   out_y       out  W      term value
//   out_idx     out  CNT_W  term index, 0-based
//   out_last    out  1      final term of the job
//   out_ovf     out  1      term is, or derives from, a wrapped sum
//   busy        out  1      1 in RUN
//
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): state=IDLE. Reset is honoured in any state,
//     including mid-job; the job is discarded.
//     Output values after reset: out_vld=0, out_last=0, out_ovf=0, busy=0,
//     start_rdy=1, out_y=0, out_idx=0.
//   State IDLE: start_rdy=1, out_vld=0.
//     On start_vld with start_n!=0: load a=x0, b=x1, rem=N, idx=0, ovf_a=0,
//     ovf_b=0, mode; go to RUN.
//     On start_vld with start_n==0: handshake completes; stay in IDLE; no output.
//   State RUN: start_rdy=0, out_vld=1, out_y=a, out_idx=idx, out_ovf=ovf_a.
//     out_last = (rem==1) | (mode==STOP & ovf_b).
//   Advance on (out_vld & out_rdy):
//     {c, s} = a + b, with s W bits and c the carry.
//     a <= b; b <= s; ovf_a <= ovf_b; ovf_b <= c | ovf_a | ovf_b (sticky).
//     idx <= idx+1; rem <= rem-1.
//     If out_last: go to IDLE. The next start can be accepted one cycle after
//     the last handshake.
//   Latency: start accepted at cycle T -> out_vld=1 with y=x0 at T+1.
//     Throughput is 1 term/cycle while out_rdy=1.
//   Backpressure: while out_vld & ~out_rdy, out_y, out_idx, out_last and
//     out_ovf are held stable.
//   STOP mode: a term with ovf set is never emitted. If N is exhausted first,
//     out_last follows rem. Both conditions true at once give the same single
//     last term.
//   abort=1 in RUN: next cycle is IDLE with out_vld=0. This overrides any
//     handshake in the same cycle; that term counts as not delivered.
//     abort in IDLE has no effect.
//   idx never wraps: idx < N <= 2^CNT_W-1.
//
// TESTING
//   1 Reset: hold rst_n=0 for 2 cycles, including once mid-job ->
//     start_rdy=1, out_vld=0, busy=0 on the following cycle.
//   2 Basic: x0=1, x1=1, N=10, WRAP, out_rdy=1 ->
//     y=1,1,2,3,5,8,13,21,34,55 on consecutive cycles; idx 0..9;
//     last only on 55; ovf=0; start_rdy=1 on the next cycle.
//   3 Wrap, W=8: x0=0, x1=1, N=16, WRAP ->
//     idx13 y=233 ovf=0; idx14 y=121 ovf=1; idx15 y=98 ovf=1, last=1.
//   4 Stop, W=8: same seeds, N=16, STOP ->
//     14 terms; last on idx13 y=233; out_ovf never 1.
//   5 Backpressure: toggle out_rdy pseudo-randomly with the test-2 job ->
//     identical sequence; fields stable while stalled.
//     Also: abort at idx4 -> out_vld=0 next cycle, then a new job is accepted.
//   6 Zero-length: start_n=0 -> handshake completes; out_vld stays 0;
//     start_rdy stays 1; busy stays 0.

Source files
------------

// File: rtl/fibonacci_seq_gen.sv
// Job-driven Fibonacci term generator: accepts seeds/count/mode over a start
// handshake and streams indexed terms with last/overflow flags over valid/ready.
module fibonacci_seq_gen #(
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_vld,
  output logic             start_rdy,
  input  logic [W-1:0]     start_x0,
  input  logic [W-1:0]     start_x1,
  input  logic [CNT_W-1:0] start_n,
  input  logic             start_mode,
  input  logic             abort,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [W-1:0]     out_y,
  output logic [CNT_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [W-1:0]     r_a, r_b, w_a_nxt, w_b_nxt, w_sum;
  logic [CNT_W-1:0] r_rem, r_idx, w_rem_nxt, w_idx_nxt;
  logic             r_ovf_a, r_ovf_b, r_mode;
  logic             w_ovf_a_nxt, w_ovf_b_nxt, w_mode_nxt;
  logic             w_carry, w_last;

  assign {w_carry, w_sum} = {1'b0, r_a} + {1'b0, r_b};

  // STOP mode ends on the term before the first wrapped one (ovf_b marks it).
  assign w_last = (r_rem == CNT_W'(1)) | (r_mode & r_ovf_b);

  assign start_rdy = (r_state == S_IDLE);
  assign out_vld   = (r_state == S_RUN);
  assign busy      = (r_state == S_RUN);
  assign out_y     = r_a;
  assign out_idx   = r_idx;
  assign out_last  = out_vld & w_last;
  assign out_ovf   = out_vld & r_ovf_a;

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_rem_nxt   = r_rem;
    w_idx_nxt   = r_idx;
    w_ovf_a_nxt = r_ovf_a;
    w_ovf_b_nxt = r_ovf_b;
    w_mode_nxt  = r_mode;
    case (r_state)
      S_IDLE: begin
        if (start_vld && (start_n != '0)) begin
          w_state_nxt = S_RUN;
          w_a_nxt     = start_x0;
          w_b_nxt     = start_x1;
          w_rem_nxt   = start_n;
          w_idx_nxt   = '0;
          w_ovf_a_nxt = 1'b0;
          w_ovf_b_nxt = 1'b0;
          w_mode_nxt  = start_mode;
        end
      end
      S_RUN: begin
        // Abort wins over a same-cycle handshake; the term is dropped.
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (out_rdy) begin
          w_a_nxt     = r_b;
          w_b_nxt     = w_sum;
          w_ovf_a_nxt = r_ovf_b;
          w_ovf_b_nxt = w_carry | r_ovf_a | r_ovf_b;
          w_idx_nxt   = r_idx + CNT_W'(1);
          w_rem_nxt   = r_rem - CNT_W'(1);
          if (w_last) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_rem   <= '0;
      r_idx   <= '0;
      r_ovf_a <= 1'b0;
      r_ovf_b <= 1'b0;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_rem   <= w_rem_nxt;
      r_idx   <= w_idx_nxt;
      r_ovf_a <= w_ovf_a_nxt;
      r_ovf_b <= w_ovf_b_nxt;
      r_mode  <= w_mode_nxt;
    end
  end

endmodule

// File: tb/tb_fibonacci_seq_gen.sv
// Directed bench: a 32-bit instance for basic/backpressure/abort/zero-length
// jobs and an 8-bit instance for wrap and stop behaviour.
module tb_fibonacci_seq_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_vld, start_vld8;
  logic [31:0] start_x0, start_x1;
  logic [15:0] start_n;
  logic        start_mode, abort, out_rdy;

  logic        start_rdy, out_vld, out_last, out_ovf, busy;
  logic [31:0] out_y;
  logic [15:0] out_idx;
  logic        start_rdy8, out_vld8, out_last8, out_ovf8, busy8;
  logic [7:0]  out_y8;
  logic [15:0] out_idx8;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] fib10 [10] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55};
  logic [31:0] fib8  [16] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121, 98};
  logic [15:0] rdy_pat = 16'b1011_0010_1101_0110;
  int unsigned k, cyc;

  always #5 clk = ~clk;

  fibonacci_seq_gen #(.W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start_vld(start_vld), .start_rdy(start_rdy),
    .start_x0(start_x0), .start_x1(start_x1), .start_n(start_n),
    .start_mode(start_mode), .abort(abort), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_y(out_y), .out_idx(out_idx), .out_last(out_last), .out_ovf(out_ovf),
    .busy(busy)
  );

  fibonacci_seq_gen #(.W(8), .CNT_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_vld(start_vld8), .start_rdy(start_rdy8),
    .start_x0(start_x0[7:0]), .start_x1(start_x1[7:0]), .start_n(start_n),
    .start_mode(start_mode), .abort(abort), .out_vld(out_vld8), .out_rdy(out_rdy),
    .out_y(out_y8), .out_idx(out_idx8), .out_last(out_last8), .out_ovf(out_ovf8),
    .busy(busy8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input bit sel);
    if (sel) begin
      chk({tag, "_rdy8"}, 32'(start_rdy8), 32'd1);
      chk({tag, "_vld8"}, 32'(out_vld8), 32'd0);
      chk({tag, "_busy8"}, 32'(busy8), 32'd0);
    end else begin
      chk({tag, "_rdy"}, 32'(start_rdy), 32'd1);
      chk({tag, "_vld"}, 32'(out_vld), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic chk_term(input string tag, input bit sel, input int unsigned i,
                          input logic [31:0] ey, input bit el, input bit eo);
    logic [31:0] y;
    logic [15:0] ix;
    logic        v, l, o;
    if (sel) begin
      y = {24'd0, out_y8}; ix = out_idx8; v = out_vld8; l = out_last8; o = out_ovf8;
    end else begin
      y = out_y; ix = out_idx; v = out_vld; l = out_last; o = out_ovf;
    end
    chk($sformatf("%s_vld%0d", tag, i), 32'(v), 32'd1);
    chk($sformatf("%s_y%0d", tag, i), y, ey);
    chk($sformatf("%s_idx%0d", tag, i), 32'(ix), 32'(i));
    chk($sformatf("%s_last%0d", tag, i), 32'(l), 32'(el));
    chk($sformatf("%s_ovf%0d", tag, i), 32'(o), 32'(eo));
  endtask

  task automatic start_job(input string tag, input bit sel, input logic [31:0] x0,
                           input logic [31:0] x1, input logic [15:0] n, input bit mode);
    start_x0 = x0; start_x1 = x1; start_n = n; start_mode = mode;
    if (sel) start_vld8 = 1'b1; else start_vld = 1'b1;
    chk({tag, "_start_rdy"}, 32'(sel ? start_rdy8 : start_rdy), 32'd1);
    step();
    start_vld = 1'b0; start_vld8 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start_vld = 1'b0; start_vld8 = 1'b0; start_x0 = '0; start_x1 = '0;
    start_n = '0; start_mode = 1'b0; abort = 1'b0; out_rdy = 1'b0;

    // 1: reset from power-up
    step(); step();
    rst_n = 1'b1;
    chk_idle("rst", 1'b0);
    chk_idle("rst", 1'b1);
    chk("rst_y", out_y, 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_ovf", 32'(out_ovf), 32'd0);

    // 1: reset mid-job
    out_rdy = 1'b1;
    start_job("mid", 1'b0, 32'd1, 32'd1, 16'd10, 1'b0);
    step(); step();
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    step(); step();
    chk_idle("midrst", 1'b0);
    rst_n = 1'b1;
    step();
    chk_idle("midrel", 1'b0);

    // 2: basic stream
    start_job("basic", 1'b0, 32'd1, 32'd1, 16'd10, 1'b0);
    for (int unsigned i = 0; i < 10; i++) begin
      chk_term("basic", 1'b0, i, fib10[i], i == 9, 1'b0);
      step();
    end
    chk_idle("basic_end", 1'b0);

    // 3: wrap on 8-bit instance
    start_job("wrap", 1'b1, 32'd0, 32'd1, 16'd16, 1'b0);
    for (int unsigned i = 0; i < 16; i++) begin
      chk_term("wrap", 1'b1, i, fib8[i], i == 15, i >= 14);
      step();
    end
    chk_idle("wrap_end", 1'b1);

    // 4: stop mode on 8-bit instance
    start_job("stop", 1'b1, 32'd0, 32'd1, 16'd16, 1'b1);
    for (int unsigned i = 0; i < 14; i++) begin
      chk_term("stop", 1'b1, i, fib8[i], i == 13, 1'b0);
      step();
    end
    chk_idle("stop_end", 1'b1);

    // 5: backpressure
    start_job("bp", 1'b0, 32'd1, 32'd1, 16'd10, 1'b0);
    k = 0; cyc = 0;
    while (k < 10 && cyc < 100) begin
      chk_term("bp", 1'b0, k, fib10[k], k == 9, 1'b0);
      out_rdy = rdy_pat[cyc % 16];
      step();
      if (out_rdy) k++;
      cyc++;
    end
    chk("bp_done", k, 32'd10);
    out_rdy = 1'b1;
    chk_idle("bp_end", 1'b0);

    // 5: abort at idx4 with a same-cycle handshake
    start_job("ab", 1'b0, 32'd1, 32'd1, 16'd10, 1'b0);
    for (int unsigned i = 0; i < 4; i++) begin
      chk_term("ab", 1'b0, i, fib10[i], 1'b0, 1'b0);
      step();
    end
    chk_term("ab", 1'b0, 4, 32'd5, 1'b0, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle("ab_end", 1'b0);
    start_job("ab2", 1'b0, 32'd2, 32'd3, 16'd3, 1'b0);
    chk_term("ab2", 1'b0, 0, 32'd2, 1'b0, 1'b0);
    step();
    chk_term("ab2", 1'b0, 1, 32'd3, 1'b0, 1'b0);
    step();
    chk_term("ab2", 1'b0, 2, 32'd5, 1'b1, 1'b0);
    step();
    chk_idle("ab2_end", 1'b0);

    // abort while idle is ignored
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle("ab_idle", 1'b0);

    // 6: zero-length job
    start_job("zero", 1'b0, 32'd7, 32'd9, 16'd0, 1'b0);
    chk_idle("zero1", 1'b0);
    step();
    chk_idle("zero2", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
